// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the RV32 pipeline.
//   Owns the fetch PC, issues word requests to instruction memory under a
//   credit limit of DEPTH (queued + outstanding), drops responses made stale by
//   a redirect, and buffers kept words {instr, pc} in an in-order queue that
//   feeds decode through a valid/ready handshake.
// Optional feature: define IF_BYPASS_EN to let a kept response go straight to
//   decode in its arrival cycle when the queue is empty.
// Ports:
//   Clk, Reset               clock (rising edge), async active-high reset
//   imem_req/imem_addr       fetch request and word address
//   imem_gnt                 request accepted this cycle
//   imem_rvalid/imem_rdata   in-order response
//   redirect/redirect_pc     flush and restart fetch at redirect_pc & ~3
//   id_valid/id_ready        handshake to decode
//   id_instr/id_pc           instruction and its PC (NOP_INSTR / 0 when idle)
module if_stage #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  logic [31:0] r_fetch_pc;
  logic [31:0] r_resp_pc;
  cnt_t        r_count;
  cnt_t        r_inflight;
  cnt_t        r_discard;
  ptr_t        r_rd_ptr;
  ptr_t        r_wr_ptr;
  logic [31:0] r_q_instr [DEPTH];
  logic [31:0] r_q_pc    [DEPTH];

  logic        w_empty;
  logic        w_credit;
  logic        w_grant;
  logic        w_kept;
  logic        w_bypass;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_redirect_pc;
  logic        w_unused_rpc;
  sum_t        w_used;

  assign w_empty       = (r_count == '0);
  assign w_used        = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_credit      = (w_used < sum_t'(DEPTH));
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused_rpc  = ^redirect_pc[1:0];

  assign imem_req  = w_credit && !redirect && !Reset;
  assign imem_addr = r_fetch_pc;
  assign w_grant   = w_credit && !redirect && imem_gnt;

  // A response is kept only once every stale word from before the last
  // redirect has been drained; a response in the redirect cycle is dropped.
  assign w_kept = imem_rvalid && (r_discard == '0) && !redirect;

`ifdef IF_BYPASS_EN
  assign w_bypass = w_kept && w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign id_valid = (!w_empty || w_bypass) && !redirect && !Reset;
  assign w_pop    = !w_empty && !redirect && id_ready;
  // A bypassed word taken by decode in its arrival cycle never enters the queue.
  assign w_push   = w_kept && !(w_bypass && id_ready);

  always_comb begin
    id_instr = NOP_INSTR;
    id_pc    = '0;
    if (id_valid) begin
`ifdef IF_BYPASS_EN
      if (w_empty) begin
        id_instr = imem_rdata;
        id_pc    = r_resp_pc;
      end else begin
        id_instr = r_q_instr[r_rd_ptr];
        id_pc    = r_q_pc[r_rd_ptr];
      end
`else
      id_instr = r_q_instr[r_rd_ptr];
      id_pc    = r_q_pc[r_rd_ptr];
`endif
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_count    <= '0;
      r_inflight <= '0;
      r_discard  <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (redirect) begin
      // Everything still outstanding is stale, except a word that returns in
      // this very cycle, which is dropped right here.
      r_fetch_pc <= w_redirect_pc;
      r_resp_pc  <= w_redirect_pc;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_inflight <= r_inflight - cnt_t'(imem_rvalid);
      r_discard  <= r_inflight - cnt_t'(imem_rvalid);
    end else begin
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      r_inflight <= r_inflight + cnt_t'(w_grant) - cnt_t'(imem_rvalid);
      if (imem_rvalid && (r_discard != '0)) begin
        r_discard <= r_discard - cnt_t'(1);
      end
      if (w_kept) begin
        r_resp_pc <= r_resp_pc + 32'd4;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      end
      r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_rdata;
      r_q_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  if_stage #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .Clk(Clk), .Reset(Reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  // Memory: in-order responses with per-request latency.
  typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
  mreq_t       mq[$];
  int unsigned last_due;
  int unsigned lat_min = 1, lat_max = 1;

  // Expected decode stream: PCs buffered (instruction derived from the PC).
  logic [31:0] mbuf[$];
  logic [31:0] m_fetch, m_resp;
  int unsigned m_discard;

  // Logs of granted addresses and consumed PCs since last reset.
  logic [31:0] glog[$];
  logic [31:0] plog[$];

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete(); mbuf.delete(); glog.delete(); plog.delete();
    m_fetch = 32'h0; m_resp = 32'h0; m_discard = 0; last_due = 0;
  endtask

  task automatic do_reset();
    Reset = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; redirect = 1'b0;
    imem_gnt = 1'b0; id_ready = 1'b0; redirect_pc = '0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_pc", id_pc, 32'h0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive memory response, check outputs, advance the model.
  task automatic step();
    logic        rv;
    logic [31:0] rd;
    bit          kept, byp, e_req, e_valid;
    logic [31:0] e_pc;
    int unsigned d;
    rv = (mq.size() != 0) && (mq[0].due <= cyc);
    rd = rv ? memword(mq[0].addr) : $urandom;
    imem_rvalid = rv;
    imem_rdata  = rd;
    @(negedge Clk);
    kept    = rv && (m_discard == 0) && !redirect;
    byp     = BYP && kept && (mbuf.size() == 0);
    e_req   = !redirect && (mbuf.size() + mq.size() < DEPTH);
    e_valid = !redirect && ((mbuf.size() != 0) || byp);
    e_pc    = (mbuf.size() != 0) ? mbuf[0] : m_resp;
    s_req = imem_req; s_addr = imem_addr; s_valid = id_valid; s_pc = id_pc;
    chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) chk("imem_addr", imem_addr, m_fetch);
    chk("id_valid", {31'b0, id_valid}, {31'b0, e_valid});
    chk("id_pc", id_pc, e_valid ? e_pc : 32'h0);
    chk("id_instr", id_instr, e_valid ? memword(e_pc) : NOP);
    if (e_valid && id_ready) plog.push_back(e_pc);
    if (redirect) begin
      m_discard = mq.size() - (rv ? 1 : 0);
      if (rv) void'(mq.pop_front());
      mbuf.delete();
      m_fetch = {redirect_pc[31:2], 2'b00};
      m_resp  = m_fetch;
    end else begin
      if (e_req && imem_gnt) begin
        d = cyc + $urandom_range(lat_max, lat_min);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mq.push_back('{addr: m_fetch, due: d});
        glog.push_back(m_fetch);
        m_fetch += 32'd4;
      end
      if (e_valid && id_ready && mbuf.size() != 0) void'(mbuf.pop_front());
      if (rv) begin
        void'(mq.pop_front());
        if (m_discard != 0) m_discard--;
        else begin
          if (!(byp && id_ready)) mbuf.push_back(m_resp);
          m_resp += 32'd4;
        end
      end
    end
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    bit gnt; bit ready;
    bit exp_req; logic [31:0] exp_addr; bit exp_valid; logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int unsigned first, p0, g0;
    logic [31:0] a0;

    // Streaming from reset, 1-cycle memory: table of expected per-cycle outputs.
    first = BYP ? 1 : 2;
    for (int i = 0; i < 12; i++) begin
      tbl[i].gnt = 1'b1; tbl[i].ready = 1'b1;
      tbl[i].exp_req = 1'b1; tbl[i].exp_addr = 32'(4 * i);
      tbl[i].exp_valid = (i >= int'(first));
      tbl[i].exp_pc = (i >= int'(first)) ? 32'(4 * (i - int'(first))) : 32'h0;
    end
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      imem_gnt = tbl[i].gnt; id_ready = tbl[i].ready;
      step();
      chk("tbl_req", {31'b0, s_req}, {31'b0, tbl[i].exp_req});
      chk("tbl_addr", s_addr, tbl[i].exp_addr);
      chk("tbl_valid", {31'b0, s_valid}, {31'b0, tbl[i].exp_valid});
      chk("tbl_pc", s_pc, tbl[i].exp_pc);
    end

    // Decode stalled: credit limit caps requests, queue fills with 0x0..0xC.
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b0;
    repeat (10) step();
    chk("stall_grants", glog.size(), DEPTH);
    chk("stall_req", {31'b0, s_req}, 32'd0);
    chk("stall_head", s_pc, 32'h0);
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("release_valid", {31'b0, s_valid}, 32'd1);
    end
    for (int k = 0; k < 4; k++) chk("release_pc", plog[k], 32'(4 * k));
    chk("resume_addr", glog[4], 32'h10);

    // Redirect with three requests outstanding on slow memory.
    do_reset();
    lat_min = 6; lat_max = 6;
    imem_gnt = 1'b1; id_ready = 1'b1;
    repeat (3) step();
    g0 = glog.size(); p0 = plog.size();
    redirect = 1'b1; redirect_pc = 32'h0000_1003;
    step();
    chk("redir_req", {31'b0, s_req}, 32'd0);
    redirect = 1'b0;
    lat_min = 1; lat_max = 1;
    repeat (14) step();
    chk("redir_addr", glog[g0], 32'h1000);
    chk("redir_first_pc", plog[p0], 32'h1000);

    // Grant withheld: address must hold, no skipped or duplicated PC afterwards.
    imem_gnt = 1'b0;
    step();
    a0 = s_addr;
    repeat (4) begin
      step();
      chk("gnt_hold_req", {31'b0, s_req}, 32'd1);
      chk("gnt_hold_addr", s_addr, a0);
    end
    imem_gnt = 1'b1;
    repeat (10) step();
    for (int j = p0; j < plog.size(); j++)
      chk("redir_seq", plog[j], 32'h1000 + 32'(4 * (j - int'(p0))));

    // PC wrap-around at the top of the address space.
    p0 = plog.size();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    repeat (10) step();
    chk("wrap0", plog[p0], 32'hFFFF_FFF8);
    chk("wrap1", plog[p0 + 1], 32'hFFFF_FFFC);
    chk("wrap2", plog[p0 + 2], 32'h0000_0000);

    // Reset asserted with a non-empty queue.
    id_ready = 1'b0;
    repeat (6) step();
    chk("pre_rst_valid", {31'b0, id_valid}, 32'd1);
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b1;
    step();
    chk("post_rst_req", {31'b0, s_req}, 32'd1);
    chk("post_rst_addr", s_addr, 32'h0);

    // Randomized traffic against the model.
    lat_min = 1; lat_max = 5;
    for (int n = 0; n < 3000; n++) begin
      imem_gnt = ($urandom_range(0, 3) != 0);
      id_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 39) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom;
      step();
    end
    redirect = 1'b0;
    chk("random_progress", {31'b0, plog.size() > 100}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
